qspi_sclk_gen: RTL

Parametrised QSPI serial-clock generator for simulation and FPGA benches, driving the flash model's `sck` from the system clock while `qspi_cs` is asserted. It is the successor of the fixed-prescaler sim clock gen. It adds:
- runtime-programmable half-period;
- selectable idle polarity (CPOL);
- a chip-select-to-first-edge lead delay;
- an optional edge-count limit;
- per-edge strobes, so bench monitors and flash models can sample without edge detection.

---
 rtl/qspi_sclk_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/qspi_sclk_gen.sv
// QSPI serial-clock generator: programmable half-period, CPOL, CS lead delay,
// optional edge limit and registered per-edge strobes.
//
// state | meaning
// IDLE  | CS high, config latched every cycle, sclk parked at cfg_cpol
// LEAD  | CS low, counting the lead delay before the first half-period
// RUN   | toggling sclk every prescaler_q+1 cycles
// HALT  | edge limit reached, sclk frozen, done held until CS rises
module qspi_sclk_gen #(
   parameter int CNT_WIDTH         = 8,
   parameter int EDGE_WIDTH        = 16,
   parameter int LEAD_CYCLES       = 2,
   parameter int DEFAULT_PRESCALER = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  qspi_cs,
   input  logic [CNT_WIDTH-1:0]  cfg_prescaler,
   input  logic                  cfg_cpol,
   input  logic [EDGE_WIDTH-1:0] cfg_max_edges,
   output logic                  qspi_sclk,
   output logic                  sclk_rise,
   output logic                  sclk_fall,
   output logic [EDGE_WIDTH-1:0] edge_count,
   output logic                  active,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN, S_HALT} state_t;

   // LEAD_CYCLES is assumed to fit in CNT_WIDTH; unused when it is 0.
   localparam logic [CNT_WIDTH-1:0] LEAD_LAST = CNT_WIDTH'(LEAD_CYCLES - 1);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  prescaler_q, prescaler_d;
   logic                  cpol_q, cpol_d;
   logic [EDGE_WIDTH-1:0] max_q, max_d;
   logic                  sclk_q, sclk_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic [EDGE_WIDTH-1:0] ecount_q, ecount_d;
   logic                  done_q, done_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prescaler_d = prescaler_q;
      cpol_d      = cpol_q;
      max_d       = max_q;
      sclk_d      = sclk_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      ecount_d    = ecount_q;
      done_d      = done_q;

      if (state_q == S_IDLE) begin
         prescaler_d = cfg_prescaler;
         cpol_d      = cfg_cpol;
         max_d       = cfg_max_edges;
         sclk_d      = cfg_cpol;
         cnt_d       = '0;
         done_d      = 1'b0;
         if (!qspi_cs) begin
            ecount_d = '0;
            state_d  = (LEAD_CYCLES == 0) ? S_RUN : S_LEAD;
         end
      end else if (qspi_cs) begin
         // CS release beats any toggle or limit event on the same edge
         state_d = S_IDLE;
         sclk_d  = cpol_q;
         done_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_LEAD: begin
               if (cnt_q == LEAD_LAST) begin
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
            S_RUN: begin
               if (cnt_q == prescaler_q) begin
                  cnt_d    = '0;
                  sclk_d   = ~sclk_q;
                  rise_d   = ~sclk_q;
                  fall_d   = sclk_q;
                  ecount_d = ecount_q + EDGE_WIDTH'(1);
                  if ((max_q != '0) && (ecount_d == max_q)) begin
                     state_d = S_HALT;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         prescaler_q <= CNT_WIDTH'(DEFAULT_PRESCALER);
         cpol_q      <= 1'b0;
         max_q       <= '0;
         sclk_q      <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         ecount_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prescaler_q <= prescaler_d;
         cpol_q      <= cpol_d;
         max_q       <= max_d;
         sclk_q      <= sclk_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         ecount_q    <= ecount_d;
         done_q      <= done_d;
      end
   end

   assign qspi_sclk  = sclk_q;
   assign sclk_rise  = rise_q;
   assign sclk_fall  = fall_q;
   assign edge_count = ecount_q;
   assign done       = done_q;
   assign active     = (state_q != S_IDLE);

endmodule
